// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, fetches words over req/gnt+rvalid and hands them to decode in order.
// Latency: a word reaches decode the cycle after rvalid; with FETCH_BYPASS_EN an empty buffer forwards it the same cycle.
// Backpressure: imem_req is held low while in-flight plus buffered words would exceed DEPTH, so inst_ready=0 stalls fetch.

module inst_fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         push,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop,
  output logic [W-1:0]                 head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          full;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= push_dat;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && !clr) begin
      assert (!(push && full && !pop));
      assert (!(pop && empty));
    end
  end
`endif
endmodule

module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] INST,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready
);
  localparam int            CW      = $clog2(DEPTH+1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pc;
  logic          run;
  logic [CW-1:0] discard;
  logic [CW-1:0] tag_cnt;
  logic [CW-1:0] dat_cnt;
  logic [31:0]   tag_head;
  logic [63:0]   dat_head;
  logic          dat_empty;
  logic          fire;
  logic          drop;
  logic          bypass;
  logic          push_word;
  logic          pop_word;

  assign fire      = imem_req & imem_gnt;
  assign drop      = (discard != '0);
  assign dat_empty = (dat_cnt == '0);
  assign pop_word  = !dat_empty & inst_ready;

`ifdef FETCH_BYPASS_EN
  assign bypass = dat_empty & !drop & imem_rvalid & !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word accepted by decode never enters the buffer.
  assign push_word = imem_rvalid & !drop & !redirect_valid & !(bypass & inst_ready);

  assign imem_req  = run & !redirect_valid &
                     (({1'b0, tag_cnt} + {1'b0, dat_cnt}) < DEPTH_W);
  assign imem_addr = pc;

  // Tags follow every granted request, including ones later discarded, so the head always matches rvalid.
  inst_fetch_fifo #(.W(32), .DEPTH(DEPTH)) u_tag_fifo (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clr      (1'b0),
    .push     (fire),
    .push_dat (pc),
    .pop      (imem_rvalid),
    .head_dat (tag_head),
    .count    (tag_cnt)
  );

  inst_fetch_fifo #(.W(64), .DEPTH(DEPTH)) u_dat_fifo (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clr      (redirect_valid),
    .push     (push_word),
    .push_dat ({tag_head, imem_rdata}),
    .pop      (pop_word),
    .head_dat (dat_head),
    .count    (dat_cnt)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      run     <= 1'b0;
      pc      <= RESET_PC;
      discard <= '0;
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        pc      <= redirect_pc & ~32'h3;
        // Everything still in flight after this cycle's response belongs to the old path.
        discard <= tag_cnt - CW'(imem_rvalid);
      end else begin
        if (fire) pc <= pc + 32'd4;
        if (imem_rvalid && drop) discard <= discard - CW'(1);
      end
    end
  end

  always_comb begin
    inst_valid = !dat_empty | bypass;
    INST       = 32'h0;
    inst_pc    = 32'h0;
    if (!dat_empty) begin
      {inst_pc, INST} = dat_head;
    end else if (bypass) begin
      INST    = imem_rdata;
      inst_pc = tag_head;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, streaming, stall, redirects, PC wrap and fetch latency.
`timescale 1ns/1ps
module tb_inst_fetch;
  localparam logic [31:0] K = 32'h00A0_0093;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] INST;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  int checks = 0;
  int errors = 0;
  logic hold = 1'b0;
  logic [31:0] pend[$];
  logic [31:0] gq[$];
  logic [31:0] pq[$];
  logic [31:0] iq[$];

  inst_fetch #(.RESET_PC(32'h100), .DEPTH(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .INST(INST), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #3;
    end
  endtask

  task automatic clear_logs();
    gq.delete();
    pq.delete();
    iq.delete();
  endtask

  // Memory: in-order responses, one cycle after grant, word = addr ^ K; hold withholds them.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge CLK);
      #1;
      if (!RST_N) begin
        pend.delete();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end else if (!hold && pend.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend.pop_front() ^ K;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        if (imem_req && imem_gnt) begin
          pend.push_back(imem_addr);
          gq.push_back(imem_addr);
        end
        if (inst_valid && inst_ready) begin
          pq.push_back(inst_pc);
          iq.push_back(INST);
        end
      end
    end
  end

  initial begin
    imem_gnt       = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state and first fetch
    step(2);
    chk_b("rst_req", imem_req, 1'b0);
    chk_b("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", INST, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h100);
    RST_N = 1'b1;
    #1;
    chk_b("req_before_edge", imem_req, 1'b0);
    step(1);
    chk_b("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h100);
    chk_b("first_valid", inst_valid, 1'b0);
    step(1);
`ifdef FETCH_BYPASS_EN
    chk_b("rv_cycle_valid", inst_valid, 1'b1);
    chk("rv_cycle_pc", inst_pc, 32'h100);
    chk("rv_cycle_inst", INST, 32'h100 ^ K);
    step(1);
    chk("next_cycle_pc", inst_pc, 32'h104);
`else
    chk_b("rv_cycle_valid", inst_valid, 1'b0);
    step(1);
    chk_b("next_cycle_valid", inst_valid, 1'b1);
    chk("next_cycle_pc", inst_pc, 32'h100);
    chk("next_cycle_inst", INST, 32'h100 ^ K);
`endif
    step(12);
    for (int i = 0; i < 3; i++) chk($sformatf("grant_%0d", i), qat(gq, i), 32'h100 + 32'(4*i));
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stream_pc_%0d", i), qat(pq, i), 32'h100 + 32'(4*i));
      chk($sformatf("stream_inst_%0d", i), qat(iq, i), (32'h100 + 32'(4*i)) ^ K);
    end

    // Mid-operation reset, then decode stall
    RST_N = 1'b0;
    #1;
    chk_b("midrst_req", imem_req, 1'b0);
    chk_b("midrst_valid", inst_valid, 1'b0);
    inst_ready = 1'b0;
    step(2);
    clear_logs();
    RST_N = 1'b1;
    step(10);
    chk("stall_grants", gq.size(), 32'd2);
    chk_b("stall_req", imem_req, 1'b0);
    chk_b("stall_valid", inst_valid, 1'b1);
    chk("stall_pc", inst_pc, 32'h100);
    chk("stall_inst", INST, 32'h100 ^ K);
    clear_logs();
    inst_ready = 1'b1;
    step(12);
    chk("unstall_pc0", qat(pq, 0), 32'h100);
    chk("unstall_pc1", qat(pq, 1), 32'h104);
    chk("unstall_pc2", qat(pq, 2), 32'h108);
    chk("unstall_grant0", qat(gq, 0), 32'h108);

    // Redirect with two requests in flight
    hold = 1'b1;
    step(6);
    chk_b("inflight_req", imem_req, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    #1;
    chk_b("redirect_req", imem_req, 1'b0);
    clear_logs();
    step(1);
    redirect_valid = 1'b0;
    hold = 1'b0;
    step(12);
    chk("redir_grant0", qat(gq, 0), 32'h200);
    chk("redir_grant1", qat(gq, 1), 32'h204);
    chk("redir_pc0", qat(pq, 0), 32'h200);
    chk("redir_inst0", qat(iq, 0), 32'h200 ^ K);
    chk("redir_pc1", qat(pq, 1), 32'h204);

    // Back-to-back redirects: latest target wins
    hold = 1'b1;
    step(6);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    clear_logs();
    step(1);
    redirect_pc = 32'h504;
    step(1);
    redirect_valid = 1'b0;
    hold = 1'b0;
    step(12);
    chk("b2b_grant0", qat(gq, 0), 32'h504);
    chk("b2b_pc0", qat(pq, 0), 32'h504);

    // Redirect in the same cycle as a response
    hold = 1'b1;
    step(6);
    hold = 1'b0;
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    clear_logs();
    step(1);
    redirect_valid = 1'b0;
    step(12);
    chk("rvredir_grant0", qat(gq, 0), 32'h300);
    chk("rvredir_pc0", qat(pq, 0), 32'h300);
    chk("rvredir_pc1", qat(pq, 1), 32'h304);

    // PC wrap from 0xFFFF_FFFC
    imem_gnt = 1'b0;
    step(6);
    chk_b("quiet_valid", inst_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step(1);
    chk_b("wrap_req", imem_req, 1'b1);
    chk("wrap_addr1", imem_addr, 32'h0);

    // Fetch latency from an empty buffer; low address bits are ignored
    imem_gnt = 1'b0;
    step(6);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2;
    step(1);
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    chk("lat_addr", imem_addr, 32'h0);
    step(1);
`ifdef FETCH_BYPASS_EN
    chk_b("lat_valid", inst_valid, 1'b1);
    chk("lat_inst", INST, K);
    chk("lat_pc", inst_pc, 32'h0);
`else
    chk_b("lat_valid", inst_valid, 1'b0);
    chk("lat_inst", INST, 32'h0);
    step(1);
    chk_b("lat_valid_next", inst_valid, 1'b1);
    chk("lat_inst_next", INST, K);
    chk("lat_pc_next", inst_pc, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
